peripheral_bin2bcd: RTL and testbench

Memory-mapped binary-to-BCD converter for the FemtoRV32 calculator, downstream of the 8x8 multiplier peripheral. Firmware reads the 16-bit product from the multiplier and writes it here. The block runs a sequential double-dabble conversion and returns five packed BCD digits for the display driver. The bus interface uses the same cs/addr/rd/wr/d_in/d_out scheme as the other calculator peripherals.

---
 rtl/peripheral_bin2bcd_pkg.sv | 35 +++
 rtl/peripheral_bin2bcd_core.sv | 66 ++++++
 rtl/peripheral_bin2bcd.sv | 74 +++++++
 tb/tb_peripheral_bin2bcd.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_bin2bcd_pkg.sv
// Shared definitions for the calculator binary-to-BCD peripheral:
// register addresses, FSM encoding and the double-dabble digit adjust.
package peripheral_bin2bcd_pkg;

    localparam logic [4:0] ADDR_DATA   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h04;
    localparam logic [4:0] ADDR_RESULT = 5'h08;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned DIGITS = 5;

    typedef struct packed {
        logic overrun;
        logic done;
        logic busy;
    } status_t;

    // Every digit of 5 or more gets +3 so the following left shift carries
    // correctly into the next decimal digit; the add wraps within 4 bits.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return adj;
    endfunction

endpackage

// File: rtl/peripheral_bin2bcd_core.sv
// Sequential double-dabble converter: one shift-and-adjust iteration per
// cycle, sixteen iterations per conversion; result held until the next one.
module bin2bcd_core
    import peripheral_bin2bcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd_out,
    output logic [1:0]  state_dbg
);

    logic [1:0]  state;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [3:0]  count;
    logic [19:0] result;

    logic [19:0] bcd_adj;
    logic [35:0] shifted;

    always_comb begin
        bcd_adj = bcd_adjust(bcd);
        shifted = {bcd_adj[18:0], bin, 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bin   <= bin_in;
                        bcd   <= '0;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= shifted;
                    count      <= count + 4'd1;
                    // count==15 marks the sixteenth iteration
                    if (count == 4'd15) begin
                        result <= shifted[35:16];
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign bcd_out   = result;
    assign state_dbg = state;

endmodule

// File: rtl/peripheral_bin2bcd.sv
// Bus wrapper for the BCD converter: address decode, sticky overrun flag
// and the registered read port.
module peripheral_bin2bcd
    import peripheral_bin2bcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out
);

    logic        busy;
    logic        done;
    logic [19:0] bcd_result;
    logic [1:0]  core_state;
    logic        overrun;

    logic        wr_data;
    logic        rd_status;
    logic        start;
    logic        overrun_set;
    status_t     status;
    logic [31:0] rd_data;

    bin2bcd_core u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (d_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_result),
        .state_dbg (core_state)
    );

    assign wr_data     = cs && wr && (addr == ADDR_DATA);
    assign rd_status   = cs && rd && (addr == ADDR_STATUS);
    assign start       = wr_data && !busy;
    // A write that lands while converting is dropped and flagged instead
    assign overrun_set = wr_data && (core_state == SHIFT);
    assign status      = '{overrun: overrun, done: done, busy: busy};

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            ADDR_STATUS: rd_data = {29'd0, status};
            ADDR_RESULT: rd_data = {12'd0, bcd_result};
            default:     rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (rd_status) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= 32'd0;
        end else if (cs && rd) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Self-checking bench for peripheral_bin2bcd: bus-level driver tasks, one
// task per scenario, decimal reference model computed with plain arithmetic.
module tb_peripheral_bin2bcd;
    import peripheral_bin2bcd_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;

    int n_cmp;
    int n_bad;

    peripheral_bin2bcd dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: decimal digits by division, packed 4 bits each
    function automatic logic [31:0] ref_result(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = 32'd0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // driver tasks: each starts and ends on a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] data);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = data;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] data);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        data = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] st);
        bit ok;
        ok = 0;
        st = 32'd0;
        for (int i = 0; i < 40; i++) begin
            bus_read(ADDR_STATUS, st);
            if (st[1]) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL done_timeout: got status %h expected done within 40 polls", st);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        idle(3);
        check("reset_dout", d_out, 32'd0);
        reset = 1'b1;
        idle(1);
        bus_read(ADDR_STATUS, v);
        check("reset_status", v, 32'd0);
        bus_read(ADDR_RESULT, v);
        check("reset_result", v, 32'd0);
    endtask

    task automatic test_zero;
        logic [31:0] v;
        bus_write(ADDR_DATA, 16'd0);
        for (int i = 0; i < 16; i++) begin
            bus_read(ADDR_STATUS, v);
            check($sformatf("zero_busy_%0d", i), v, 32'h1);
        end
        bus_read(ADDR_STATUS, v);
        check("zero_done", v, 32'h2);
        bus_read(ADDR_RESULT, v);
        check("zero_result", v, 32'h0);
    endtask

    task automatic test_products;
        logic [31:0] v;
        bus_write(ADDR_DATA, 16'hFE01);
        wait_done(v);
        bus_read(ADDR_RESULT, v);
        check("fe01_result", v, 32'h00065025);
        check("fe01_model", v, ref_result(65025));
    endtask

    task automatic test_restart_from_done;
        logic [31:0] v;
        bus_write(ADDR_DATA, 16'hFFFF);
        wait_done(v);
        bus_read(ADDR_RESULT, v);
        check("ffff_result", v, 32'h00065535);
        bus_write(ADDR_DATA, 16'd9);
        bus_read(ADDR_STATUS, v);
        check("restart_busy", v, 32'h1);
        bus_read(ADDR_RESULT, v);
        check("restart_hold", v, 32'h00065535);
        wait_done(v);
        bus_read(ADDR_RESULT, v);
        check("restart_result", v, 32'h00000009);
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        bus_write(ADDR_DATA, 16'd1234);
        idle(2);
        bus_write(ADDR_DATA, 16'd999);
        idle(20);
        bus_read(ADDR_STATUS, v);
        check("overrun_set", v, 32'h6);
        bus_read(ADDR_STATUS, v);
        check("overrun_clear", v, 32'h2);
        bus_read(ADDR_RESULT, v);
        check("overrun_result", v, 32'h00001234);
    endtask

    task automatic test_unmapped;
        logic [31:0] v;
        bus_read(ADDR_RESULT, v);
        bus_read(5'h1C, v);
        check("unmapped_read", v, 32'd0);
        bus_write(ADDR_STATUS, 16'h1234);
        bus_read(ADDR_STATUS, v);
        check("status_write_ignored", v, 32'h2);
        bus_read(ADDR_RESULT, v);
        check("status_write_result", v, 32'h00001234);
    endtask

    task automatic test_random;
        logic [31:0] v;
        int unsigned x;
        for (int i = 0; i < 10; i++) begin
            x = $urandom_range(0, 65535);
            bus_write(ADDR_DATA, 16'(x));
            wait_done(v);
            check($sformatf("rand_status_%0d", i), v, 32'h2);
            bus_read(ADDR_RESULT, v);
            check($sformatf("rand_result_%0d_%0d", i, x), v, ref_result(x));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        int unsigned a;
        int unsigned b;
        a = $urandom_range(0, 65535);
        b = $urandom_range(0, 65535);
        bus_write(ADDR_DATA, 16'(a));
        idle(16);
        bus_write(ADDR_DATA, 16'(b));
        bus_read(ADDR_STATUS, v);
        check("b2b_accepted", v, 32'h1);
        wait_done(v);
        check("b2b_no_overrun", v, 32'h2);
        bus_read(ADDR_RESULT, v);
        check("b2b_result", v, ref_result(b));
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] v;
        bus_read(ADDR_RESULT, v);
        bus_write(ADDR_DATA, 16'hABCD);
        idle(5);
        reset = 1'b0;
        #1;
        check("midreset_dout", d_out, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        bus_read(ADDR_STATUS, v);
        check("midreset_status", v, 32'd0);
        bus_read(ADDR_RESULT, v);
        check("midreset_result", v, 32'd0);
        bus_write(ADDR_DATA, 16'd42);
        wait_done(v);
        bus_read(ADDR_RESULT, v);
        check("midreset_42", v, 32'h00000042);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_zero;
        test_products;
        test_restart_from_done;
        test_overrun;
        test_unmapped;
        test_random;
        test_back_to_back;
        test_reset_mid_shift;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
